// File: rtl/lcd_timing_controller.sv
// LCD scan timing generator: dot/line counters, PPU mode, LY, LY/LYC
// coincidence, pixel coordinate strobe and VBlank/STAT interrupt requests.
module lcd_timing_controller #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int FETCH_LEAD    = 12,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       pixel_valid,
    output logic [7:0] pixel_x,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq
);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] XFER_START   = 9'(OAM_DOTS);
    localparam logic [8:0] HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [8:0] PIX_START    = 9'(OAM_DOTS + FETCH_LEAD);
    localparam logic [7:0] LINE_LAST    = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] VBLANK_LINE  = 8'(VISIBLE_LINES);

    // p0: next counter values and their decode; p1: registered scan
    // position and outputs; p2: STAT line history and interrupt pulses.
    logic [8:0] dot_p0,  dot_p1;
    logic [7:0] line_p0, line_p1;
    logic [1:0] mode_p0, mode_p1;
    logic       pix_vld_p0;
    logic [7:0] pix_x_p0;
    logic       active_p1;   // counters are running (dot 0 already presented)
    logic       vld_p1;      // counters moved on the previous clock
    logic       stat_line;
    logic       stat_line_p2;

    function automatic logic [1:0] decode_mode(input logic [8:0] d, input logic [7:0] l);
        if (l >= VBLANK_LINE)
            return MODE_VBLANK;
        else if (d < XFER_START)
            return MODE_OAM;
        else if (d < HBLANK_START)
            return MODE_XFER;
        else
            return MODE_HBLANK;
    endfunction

    // Next-state: advance dot/line; the first dot after enable or reset is line 0, dot 0.
    always_comb begin
        dot_p0  = dot_p1;
        line_p0 = line_p1;
        if (!active_p1) begin
            dot_p0  = '0;
            line_p0 = '0;
        end else if (dot_p1 == DOT_LAST) begin
            dot_p0  = '0;
            line_p0 = (line_p1 == LINE_LAST) ? 8'd0 : line_p1 + 8'd1;
        end else begin
            dot_p0 = dot_p1 + 9'd1;
        end
        mode_p0 = decode_mode(dot_p0, line_p0);
    end

    // Output decode: pixel strobe for the upcoming dot and the current STAT line level.
    always_comb begin
        pix_vld_p0 = (mode_p0 == MODE_XFER) && (dot_p0 >= PIX_START);
        pix_x_p0   = pix_vld_p0 ? 8'(dot_p0 - PIX_START) : 8'd0;
        stat_line  = active_p1 &
                     ((stat_ie[3] & (line_p1 == lyc)) |
                      (stat_ie[2] & (mode_p1 == MODE_OAM)) |
                      (stat_ie[1] & (mode_p1 == MODE_VBLANK)) |
                      (stat_ie[0] & (mode_p1 == MODE_HBLANK)));
    end

    // State register: scan position, mode and per-dot outputs, updated on dot strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dot_p1      <= '0;
            line_p1     <= '0;
            mode_p1     <= MODE_HBLANK;
            active_p1   <= 1'b0;
            vld_p1      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!lcd_enable) begin
            dot_p1      <= '0;
            line_p1     <= '0;
            mode_p1     <= MODE_HBLANK;
            active_p1   <= 1'b0;
            vld_p1      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (dot_en) begin
            dot_p1      <= dot_p0;
            line_p1     <= line_p0;
            mode_p1     <= mode_p0;
            active_p1   <= 1'b1;
            vld_p1      <= 1'b1;
            pixel_valid <= pix_vld_p0;
            pixel_x     <= pix_x_p0;
            line_start  <= (dot_p0 == 9'd0);
            frame_start <= (dot_p0 == 9'd0) && (line_p0 == 8'd0);
        end else begin
            vld_p1      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    // Interrupts: STAT rising-edge detect, VBlank entry pulse, LY/LYC compare.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coincidence  <= 1'b0;
            stat_line_p2 <= 1'b0;
            stat_irq     <= 1'b0;
            vblank_irq   <= 1'b0;
        end else begin
            coincidence <= (line_p1 == lyc);
            if (!lcd_enable) begin
                stat_line_p2 <= 1'b0;
                stat_irq     <= 1'b0;
                vblank_irq   <= 1'b0;
            end else begin
                stat_line_p2 <= stat_line;
                stat_irq     <= stat_line & ~stat_line_p2;
                vblank_irq   <= vld_p1 && (line_p1 == VBLANK_LINE) && (dot_p1 == 9'd0);
            end
        end
    end

    assign ly   = line_p1;
    assign mode = mode_p1;

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Scoreboard bench for lcd_timing_controller: stimulus queues expected pulses
// and level samples by cycle number; monitors pop and compare them.
module tb_lcd_timing_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       dot_en = 1'b0;
    logic       lcd_enable = 1'b1;
    logic [7:0] lyc = 8'd5;
    logic [3:0] stat_ie = 4'b1000;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       coincidence;
    logic       pixel_valid;
    logic [7:0] pixel_x;
    logic       line_start;
    logic       frame_start;
    logic       vblank_irq;
    logic       stat_irq;

    lcd_timing_controller dut (
        .clock(clock), .reset_n(reset_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
        .lyc(lyc), .stat_ie(stat_ie), .ly(ly), .mode(mode), .coincidence(coincidence),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .line_start(line_start),
        .frame_start(frame_start), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
    );

    localparam int K_LS = 0, K_FS = 1, K_VB = 2, K_ST = 3;
    localparam int LINE = 456;
    localparam int FRAME = 70224;

    typedef struct {int cyc; int ly;} pev_t;
    typedef struct {int cyc; int ly; int mode; int pv; int px; int co;} lev_t;

    pev_t pq[4][$];
    lev_t lvq[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int frame_lo = 0, frame_hi = 0;
    int pix_cnt = 0, vb_pix = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    task automatic exp_lvl(input int c, input int l, input int m, input int p, input int x, input int co);
        lvq.push_back('{c, l, m, p, x, co});
    endtask

    task automatic exp_pulse(input int k, input int c, input int l);
        pq[k].push_back('{c, l});
    endtask

    // Line 0 timing reference points, relative to the clock that presents dot 0.
    task automatic exp_line0(input int b, input int co);
        exp_lvl(b + 0,   0, 2, 0, 0,   co);
        exp_lvl(b + 79,  0, 2, 0, 0,   co);
        exp_lvl(b + 80,  0, 3, 0, 0,   co);
        exp_lvl(b + 91,  0, 3, 0, 0,   co);
        exp_lvl(b + 92,  0, 3, 1, 0,   co);
        exp_lvl(b + 251, 0, 3, 1, 159, co);
        exp_lvl(b + 252, 0, 0, 0, 0,   co);
        exp_lvl(b + 455, 0, 0, 0, 0,   co);
        exp_lvl(b + 456, 1, 2, 0, 0,   co);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic chk_pulse(input int k, input logic v, input string nm);
        pev_t e;
        if (pq[k].size() > 0 && pq[k][0].cyc < cyc) begin
            e = pq[k].pop_front();
            total++;
            bad++;
            $display("FAIL %s missing: got no pulse, expected one at cyc %0d ly %0d", nm, e.cyc, e.ly);
        end
        if (v) begin
            if (pq[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s unexpected: got pulse at cyc %0d ly %0d, expected none", nm, cyc, ly);
            end else begin
                e = pq[k].pop_front();
                chk({nm, "_cyc"}, cyc, e.cyc);
                chk({nm, "_ly"}, int'(ly), e.ly);
            end
        end
    endtask

    // Monitor: level samples at queued cycles, every pulse against its queue, pixel tallies.
    always @(negedge clock) begin
        lev_t e;
        while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
            e = lvq.pop_front();
            if (e.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL level_sample skipped: got cyc %0d, expected cyc %0d", cyc, e.cyc);
            end else begin
                chk("ly", int'(ly), e.ly);
                chk("mode", int'(mode), e.mode);
                chk("pixel_valid", int'(pixel_valid), e.pv);
                chk("coincidence", int'(coincidence), e.co);
                if (e.pv != 0) chk("pixel_x", int'(pixel_x), e.px);
            end
        end
        chk_pulse(K_LS, line_start, "line_start");
        chk_pulse(K_FS, frame_start, "frame_start");
        chk_pulse(K_VB, vblank_irq, "vblank_irq");
        chk_pulse(K_ST, stat_irq, "stat_irq");
        if (cyc >= frame_lo && cyc < frame_hi) begin
            if (pixel_valid) pix_cnt++;
            if (pixel_valid && ly >= 8'd144) vb_pix++;
        end
    end

    // Monitor: outputs must clear as soon as reset asserts, before any clock edge.
    always @(negedge reset_n) begin
        #1;
        chk("rst_ly", int'(ly), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_coincidence", int'(coincidence), 0);
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_pixel_x", int'(pixel_x), 0);
        chk("rst_pulses", int'({line_start, frame_start, vblank_irq, stat_irq}), 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int t0, e, r, s0;
        #1 reset_n = 1'b0;
        exp_lvl(2, 0, 0, 0, 0, 0);
        run_until(3);
        reset_n = 1'b1;
        run_until(5);

        // Normal line, full frame, LYC=5 coincidence, then STAT blocking with ie=0011.
        t0 = cyc + 1;
        e  = t0 + FRAME + 50 * LINE + 200;
        exp_line0(t0, 0);
        exp_lvl(t0 + 5 * LINE,       5, 2, 0, 0, 0);
        exp_lvl(t0 + 5 * LINE + 1,   5, 2, 0, 0, 1);
        exp_lvl(t0 + 6 * LINE,       6, 2, 0, 0, 1);
        exp_lvl(t0 + 6 * LINE + 1,   6, 2, 0, 0, 0);
        exp_lvl(t0 + 144 * LINE,     144, 1, 0, 0, 0);
        exp_lvl(t0 + 153 * LINE + 455, 153, 1, 0, 0, 0);
        exp_lvl(t0 + FRAME,          0, 2, 0, 0, 0);
        exp_lvl(e,                   0, 0, 0, 0, 0);
        exp_lvl(e + 2,               0, 0, 0, 0, 1);
        for (int k = 0; k <= 204; k++) exp_pulse(K_LS, t0 + k * LINE, k % 154);
        exp_pulse(K_FS, t0, 0);
        exp_pulse(K_FS, t0 + FRAME, 0);
        exp_pulse(K_VB, t0 + 144 * LINE + 1, 144);
        exp_pulse(K_ST, t0 + 5 * LINE + 1, 5);
        for (int l = 20; l <= 143; l++) exp_pulse(K_ST, t0 + l * LINE + 253, l);
        for (int l = 0; l <= 49; l++) exp_pulse(K_ST, t0 + FRAME + l * LINE + 253, l);
        frame_lo = t0;
        frame_hi = t0 + FRAME;
        dot_en = 1'b1;
        run_until(t0 + 20 * LINE + 100);
        stat_ie = 4'b0011;

        // Drop enable at line 50, dot 200; coincidence keeps tracking but cannot interrupt.
        run_until(e - 1);
        lcd_enable = 1'b0;
        lyc = 8'd0;
        stat_ie = 4'b1000;
        run_until(e + 5);

        // Re-enable: line 0 timing restarts, frame_start pulses, LYC=0 raises STAT.
        r = cyc + 1;
        exp_line0(r, 1);
        exp_pulse(K_LS, r, 0);
        exp_pulse(K_LS, r + LINE, 1);
        exp_pulse(K_FS, r, 0);
        exp_pulse(K_ST, r + 1, 0);
        lcd_enable = 1'b1;
        run_until(r + 460);
        lcd_enable = 1'b0;
        dot_en = 1'b0;
        run_until(r + 463);

        // Stalled dots (1 in 4), mode 2 STAT source, then async reset mid mode 3.
        s0 = cyc + 1;
        exp_lvl(s0 + 319, 0, 2, 0, 0, 0);
        exp_lvl(s0 + 320, 0, 3, 0, 0, 0);
        exp_lvl(s0 + 368, 0, 3, 1, 0, 0);
        exp_lvl(s0 + 371, 0, 3, 1, 0, 0);
        exp_lvl(s0 + 372, 0, 3, 1, 1, 0);
        exp_pulse(K_LS, s0, 0);
        exp_pulse(K_FS, s0, 0);
        exp_pulse(K_ST, s0 + 1, 0);
        lyc = 8'd200;
        stat_ie = 4'b0100;
        lcd_enable = 1'b1;
        for (int i = 0; i < 4 * 95 + 2; i++) begin
            dot_en = (i % 4 == 0);
            @(negedge clock);
        end
        #2 reset_n = 1'b0;
        #20;

        chk("left_line_start", pq[K_LS].size(), 0);
        chk("left_frame_start", pq[K_FS].size(), 0);
        chk("left_vblank_irq", pq[K_VB].size(), 0);
        chk("left_stat_irq", pq[K_ST].size(), 0);
        chk("left_levels", lvq.size(), 0);
        chk("frame_pixels", pix_cnt, 144 * 160);
        chk("vblank_pixels", vb_pix, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
